// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: the instruction
// memory, the branch-predict/forwarding controller and the EX/MEM resolver.
// The master side is the fetch stage itself.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_inst;
  logic             stall;
  logic             is_ctrl;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [31:0]      resolve_target;
  logic [31:0]      IF_ID_pc;
  logic [31:0]      IF_ID_inst;
  logic             IF_ID_valid;
  logic             flush;
  logic             fetch_hold;
  logic             underflow_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  modport master (
    output imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid, flush, fetch_hold,
           underflow_err, br_cnt, mis_cnt,
    input  imem_inst, stall, is_ctrl, pred_taken, pred_target,
           resolve_valid, resolve_taken, resolve_target
  );

  modport slave (
    input  imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid, flush, fetch_hold,
           underflow_err, br_cnt, mis_cnt,
    output imem_inst, stall, is_ctrl, pred_taken, pred_target,
           resolve_valid, resolve_taken, resolve_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register. Owns the PC, applies the
// controller's predicted redirect and load-use stall, tracks in-flight
// predictions in a small FIFO and recovers when EX/MEM reports a mispredict.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);
  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Fetch (p0) and IF/ID (p1) state
  logic [31:0]      pc_p0;
  logic [31:0]      if_pc_p1;
  logic [31:0]      if_inst_p1;
  logic             vld_p1;

  // Prediction FIFO: control via pointers/count, payload in plain arrays
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_taken [DEPTH];
  logic [31:0]      fifo_tgt   [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];

  logic             underflow;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  logic             push;
  logic             pop;
  logic             hold;
  logic             do_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_taken;
  logic [31:0]      head_tgt;
  logic [31:0]      head_pc;
  logic             mispredict;
  logic [31:0]      correct_pc;

  // Handshake decode: push/pop qualification, hold and mispredict detection
  always_comb begin
    fifo_full  = (count == CW'(DEPTH));
    fifo_empty = (count == '0);
    push       = vld_p1 & bus.is_ctrl & ~bus.stall;
    pop        = bus.resolve_valid & ~fifo_empty;
    hold       = bus.stall | (push & fifo_full & ~pop);
    do_push    = push & ~hold;
    head_taken = fifo_taken[rd_ptr];
    head_tgt   = fifo_tgt[rd_ptr];
    head_pc    = fifo_pc[rd_ptr];
    mispredict = pop & ((head_taken != bus.resolve_taken) |
                        (bus.resolve_taken & (head_tgt != bus.resolve_target)));
    correct_pc = bus.resolve_taken ? bus.resolve_target : head_pc + 32'd4;
  end

  // PC, IF/ID, FIFO control and statistics; mispredict outranks hold outranks taken redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0      <= RESET_PC;
      if_pc_p1   <= '0;
      if_inst_p1 <= NOP;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      underflow  <= 1'b0;
      br_cnt     <= '0;
      mis_cnt    <= '0;
    end else begin
      if (bus.resolve_valid & fifo_empty)
        underflow <= 1'b1;

      if (mispredict) begin
        pc_p0      <= correct_pc;
        if_inst_p1 <= NOP;
        vld_p1     <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        br_cnt     <= sat_inc(br_cnt);
        mis_cnt    <= sat_inc(mis_cnt);
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          br_cnt <= sat_inc(br_cnt);
        end
        if (do_push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        count <= count + CW'(do_push) - CW'(pop);

        if (hold) begin
          pc_p0 <= pc_p0;
        end else if (push & bus.pred_taken) begin
          // The sequential word fetched behind a taken branch is squashed.
          pc_p0      <= bus.pred_target;
          if_inst_p1 <= NOP;
          vld_p1     <= 1'b0;
        end else begin
          pc_p0      <= pc_p0 + 32'd4;
          if_pc_p1   <= pc_p0;
          if_inst_p1 <= bus.imem_inst;
          vld_p1     <= 1'b1;
        end
      end
    end
  end

  // FIFO payload capture; a push only lands when no mispredict discards it
  always_ff @(posedge clk) begin
    if (do_push & ~mispredict) begin
      fifo_taken[wr_ptr] <= bus.pred_taken;
      fifo_tgt[wr_ptr]   <= bus.pred_target;
      fifo_pc[wr_ptr]    <= if_pc_p1;
    end
  end

  assign bus.imem_addr     = pc_p0;
  assign bus.IF_ID_pc      = if_pc_p1;
  assign bus.IF_ID_inst    = if_inst_p1;
  assign bus.IF_ID_valid   = vld_p1;
  assign bus.flush         = mispredict;
  assign bus.fetch_hold    = hold;
  assign bus.underflow_err = underflow;
  assign bus.br_cnt        = br_cnt;
  assign bus.mis_cnt       = mis_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a table of per-cycle vectors covering
// sequential fetch, taken redirect, resolve/mispredict, stall and FIFO-full,
// followed by hand-written saturation and mid-run reset sequences.
module tb_fetch_stage;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: an addi x0 word tagged with its own address.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  assign bus.imem_inst = inst_at(bus.imem_addr);

  typedef struct {
    logic        st;
    logic        ic;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        e_flush;
    logic        e_hold;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ifpc;
    int          e_br;
    int          e_mis;
    logic        e_und;
  } vec_t;

  vec_t vecs [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ic, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    bus.stall          = st;
    bus.is_ctrl        = ic;
    bus.pred_taken     = pt;
    bus.pred_target    = ptgt;
    bus.resolve_valid  = rv;
    bus.resolve_taken  = rt;
    bus.resolve_target = rtgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.st, v.ic, v.pt, v.ptgt, v.rv, v.rt, v.rtgt);
    #1;
    chk($sformatf("v%0d flush", idx), 32'(bus.flush), 32'(v.e_flush));
    chk($sformatf("v%0d fetch_hold", idx), 32'(bus.fetch_hold), 32'(v.e_hold));
    tick();
    chk($sformatf("v%0d imem_addr", idx), bus.imem_addr, v.e_addr);
    chk($sformatf("v%0d IF_ID_valid", idx), 32'(bus.IF_ID_valid), 32'(v.e_valid));
    if (v.e_valid) begin
      chk($sformatf("v%0d IF_ID_pc", idx), bus.IF_ID_pc, v.e_ifpc);
      chk($sformatf("v%0d IF_ID_inst", idx), bus.IF_ID_inst, inst_at(v.e_ifpc));
    end else begin
      chk($sformatf("v%0d IF_ID_inst nop", idx), bus.IF_ID_inst, NOP);
    end
    chk($sformatf("v%0d br_cnt", idx), 32'(bus.br_cnt), 32'(v.e_br));
    chk($sformatf("v%0d mis_cnt", idx), 32'(bus.mis_cnt), 32'(v.e_mis));
    chk($sformatf("v%0d underflow_err", idx), 32'(bus.underflow_err), 32'(v.e_und));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    //          st ic pt ptgt      rv rt rtgt        fl hd addr      vl ifpc     br mis und
    vecs[0]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h04,  1, 32'h00,  0, 0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h08,  1, 32'h04,  0, 0, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h0c,  1, 32'h08,  0, 0, 0};
    vecs[3]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h10,  1, 32'h0c,  0, 0, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h14,  1, 32'h10,  0, 0, 0};
    vecs[5]  = '{0, 1, 1, 32'h40,  0, 0, 32'h0,      0, 0, 32'h40,  0, 32'h0,   0, 0, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h44,  1, 32'h40,  0, 0, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,   1, 1, 32'h40,     0, 0, 32'h48,  1, 32'h44,  1, 0, 0};
    vecs[8]  = '{0, 1, 1, 32'h80,  0, 0, 32'h0,      0, 0, 32'h80,  0, 32'h0,   1, 0, 0};
    vecs[9]  = '{0, 0, 0, 32'h0,   1, 0, 32'h0,      1, 0, 32'h48,  0, 32'h0,   2, 1, 0};
    vecs[10] = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h4c,  1, 32'h48,  2, 1, 0};
    vecs[11] = '{1, 1, 1, 32'h100, 0, 0, 32'h0,      0, 1, 32'h4c,  1, 32'h48,  2, 1, 0};
    vecs[12] = '{1, 1, 1, 32'h100, 0, 0, 32'h0,      0, 1, 32'h4c,  1, 32'h48,  2, 1, 0};
    vecs[13] = '{1, 1, 1, 32'h100, 0, 0, 32'h0,      0, 1, 32'h4c,  1, 32'h48,  2, 1, 0};
    vecs[14] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h50,  1, 32'h4c,  2, 1, 0};
    vecs[15] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h54,  1, 32'h50,  2, 1, 0};
    vecs[16] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h58,  1, 32'h54,  2, 1, 0};
    vecs[17] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h5c,  1, 32'h58,  2, 1, 0};
    vecs[18] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 1, 32'h5c,  1, 32'h58,  2, 1, 0};
    vecs[19] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 1, 32'h5c,  1, 32'h58,  2, 1, 0};
    vecs[20] = '{0, 1, 0, 32'h0,   1, 0, 32'h0,      0, 0, 32'h60,  1, 32'h5c,  3, 1, 0};
    vecs[21] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 1, 32'h60,  1, 32'h5c,  3, 1, 0};
    vecs[22] = '{0, 0, 0, 32'h0,   1, 0, 32'h0,      0, 0, 32'h64,  1, 32'h60,  4, 1, 0};
    vecs[23] = '{0, 0, 0, 32'h0,   1, 1, 32'h200,    1, 0, 32'h200, 0, 32'h0,   5, 2, 0};
    vecs[24] = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h204, 1, 32'h200, 5, 2, 0};
    vecs[25] = '{0, 1, 1, 32'h300, 0, 0, 32'h0,      0, 0, 32'h300, 0, 32'h0,   5, 2, 0};
    vecs[26] = '{0, 0, 0, 32'h0,   1, 1, 32'h304,    1, 0, 32'h304, 0, 32'h0,   6, 3, 0};
    vecs[27] = '{0, 0, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h308, 1, 32'h304, 6, 3, 0};
    vecs[28] = '{0, 0, 0, 32'h0,   1, 1, 32'h900,    0, 0, 32'h30c, 1, 32'h308, 6, 3, 1};
    vecs[29] = '{0, 1, 0, 32'h0,   0, 0, 32'h0,      0, 0, 32'h310, 1, 32'h30c, 6, 3, 1};
    vecs[30] = '{0, 1, 1, 32'h500, 1, 1, 32'h700,    1, 0, 32'h700, 0, 32'h0,   7, 4, 1};
    vecs[31] = '{0, 0, 0, 32'h0,   1, 0, 32'h0,      0, 0, 32'h704, 1, 32'h700, 7, 4, 1};

    // Reset held for two edges
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset imem_addr", bus.imem_addr, 32'h0);
    chk("reset IF_ID_valid", 32'(bus.IF_ID_valid), 32'h0);
    chk("reset IF_ID_inst", bus.IF_ID_inst, NOP);
    chk("reset IF_ID_pc", bus.IF_ID_pc, 32'h0);
    chk("reset underflow_err", 32'(bus.underflow_err), 32'h0);
    chk("reset br_cnt", 32'(bus.br_cnt), 32'h0);
    chk("reset mis_cnt", 32'(bus.mis_cnt), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++)
      apply(vecs[i], i);

    // Saturation: repeated push+pop of not-taken branches, counter must stop at 15
    for (int i = 0; i < 22; i++) begin
      drive(0, 1, 0, 32'h0, 1, 0, 32'h0);
      #1;
      chk($sformatf("sat%0d flush", i), 32'(bus.flush), 32'h0);
      tick();
    end
    chk("sat br_cnt", 32'(bus.br_cnt), 32'd15);
    chk("sat mis_cnt", 32'(bus.mis_cnt), 32'd4);
    chk("sat imem_addr", bus.imem_addr, 32'h75c);
    chk("sat underflow sticky", 32'(bus.underflow_err), 32'h1);

    // Fill FIFO to three entries, then reset with a mispredicting resolve pending
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    drive(0, 0, 0, 32'h0, 1, 1, 32'h800);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst-mid imem_addr", bus.imem_addr, 32'h0);
    chk("rst-mid IF_ID_valid", 32'(bus.IF_ID_valid), 32'h0);
    chk("rst-mid br_cnt", 32'(bus.br_cnt), 32'h0);
    chk("rst-mid mis_cnt", 32'(bus.mis_cnt), 32'h0);
    chk("rst-mid underflow_err", 32'(bus.underflow_err), 32'h0);

    // FIFO must be empty after reset: a resolve now is an underflow, not a flush
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    #1;
    chk("post-rst flush", 32'(bus.flush), 32'h0);
    tick();
    chk("post-rst underflow_err", 32'(bus.underflow_err), 32'h1);
    chk("post-rst imem_addr", bus.imem_addr, 32'h4);
    chk("post-rst br_cnt", 32'(bus.br_cnt), 32'h0);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
